// File: rtl/hpdcache_cmo_req_tracker.sv
// Converts core CMO requests into HPDcache CMO requests, tracking up to NTags in flight
// and returning per-request acks tagged with the original core transaction ID.
module hpdcache_cmo_req_tracker #(
    parameter int unsigned NTags        = 4,
    parameter int unsigned CoreTidWidth = 3,
    parameter int unsigned AddrWidth    = 40,
    parameter int unsigned SidWidth     = 3,
    parameter int unsigned DTidWidth    = 6,
    parameter bit          WaitRsp      = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [SidWidth-1:0]     sid_i,
    input  logic                    core_req_valid_i,
    output logic                    core_req_ready_o,
    input  logic [3:0]              core_req_op_i,
    input  logic [AddrWidth-1:0]    core_req_addr_i,
    input  logic [CoreTidWidth-1:0] core_req_tid_i,
    output logic                    core_ack_o,
    output logic [CoreTidWidth-1:0] core_ack_tid_o,
    output logic                    core_ack_err_o,
    output logic                    dcache_req_valid_o,
    input  logic                    dcache_req_ready_i,
    output logic [AddrWidth-1:0]    dcache_req_addr_o,
    output logic [2:0]              dcache_req_cmo_o,
    output logic [SidWidth-1:0]     dcache_req_sid_o,
    output logic [DTidWidth-1:0]    dcache_req_tid_o,
    output logic                    dcache_req_need_rsp_o,
    input  logic                    dcache_rsp_valid_i,
    input  logic [DTidWidth-1:0]    dcache_rsp_tid_i,
    input  logic [SidWidth-1:0]     dcache_rsp_sid_i
);
    localparam int unsigned TW = (NTags > 1) ? $clog2(NTags) : 1;

    typedef enum logic {IDLE, SEND} state_e;

    state_e                  state_q, state_d;
    logic [NTags-1:0]        tag_valid_q, tag_valid_d;
    logic [CoreTidWidth-1:0] tag_ctid_q [NTags];
    logic                    local_pend_q, local_pend_d;
    logic                    local_err_q, local_err_d;
    logic [CoreTidWidth-1:0] local_tid_q, local_tid_d;
    logic                    ack_d, ack_err_d;
    logic [CoreTidWidth-1:0] ack_tid_d;
    logic [AddrWidth-1:0]    addr_d;
    logic [2:0]              cmo_d;
    logic [DTidWidth-1:0]    tid_d;

    logic                    full_c, accept_c, alloc_c, unsup_c, hs_c, loc_c, rsp_hit_c;
    logic [TW-1:0]           free_tag_c, sent_tag_c, rsp_tag_c;
    logic [2:0]              cmo_c;

    function automatic logic [2:0] map_cmo(input logic [3:0] op);
        case (op)
            4'd0:       return 3'd1;
            4'd1:       return 3'd2;
            4'd2:       return 3'd3;
            4'd4, 4'd5: return 3'd4;
            4'd6:       return 3'd5;
            4'd7:       return 3'd6;
            4'd8:       return 3'd7;
            default:    return 3'd0;
        endcase
    endfunction

    assign dcache_req_sid_o      = sid_i;
    assign dcache_req_need_rsp_o = WaitRsp;
    assign dcache_req_valid_o    = (state_q == SEND);

    // Handshake qualification and tag selection from registered table state
    always_comb begin
        full_c     = &tag_valid_q;
        free_tag_c = '0;
        for (int i = int'(NTags) - 1; i >= 0; i--) begin
            if (!tag_valid_q[i]) free_tag_c = TW'(i);
        end
        cmo_c            = map_cmo(core_req_op_i);
        core_req_ready_o = !full_c && ((state_q == IDLE) || dcache_req_ready_i) && !local_pend_q;
        accept_c         = core_req_valid_i && core_req_ready_o;
        alloc_c          = accept_c && (cmo_c != 3'd0);
        unsup_c          = accept_c && (cmo_c == 3'd0);
        hs_c             = dcache_req_valid_o && dcache_req_ready_i;
        loc_c            = !WaitRsp && hs_c;
        sent_tag_c       = dcache_req_tid_o[TW-1:0];
        rsp_tag_c        = dcache_rsp_tid_i[TW-1:0];
        rsp_hit_c        = WaitRsp && dcache_rsp_valid_i && (dcache_rsp_sid_i == sid_i) &&
                           (dcache_rsp_tid_i < DTidWidth'(NTags)) && tag_valid_q[rsp_tag_c];
    end

    // Next-state: output FSM, tag table, local completion and ack arbitration
    always_comb begin
        state_d      = state_q;
        tag_valid_d  = tag_valid_q;
        local_pend_d = local_pend_q;
        local_err_d  = local_err_q;
        local_tid_d  = local_tid_q;
        ack_d        = 1'b0;
        ack_err_d    = 1'b0;
        ack_tid_d    = '0;
        addr_d       = dcache_req_addr_o;
        cmo_d        = dcache_req_cmo_o;
        tid_d        = dcache_req_tid_o;

        case (state_q)
            IDLE:    if (alloc_c) state_d = SEND;
            SEND:    if (hs_c) state_d = alloc_c ? SEND : IDLE;
            default: state_d = IDLE;
        endcase

        if (alloc_c) begin
            addr_d = core_req_addr_i;
            cmo_d  = cmo_c;
            tid_d  = DTidWidth'(free_tag_c);
        end

        if (rsp_hit_c) tag_valid_d[rsp_tag_c] = 1'b0;
        if (loc_c)     tag_valid_d[sent_tag_c] = 1'b0;
        if (alloc_c)   tag_valid_d[free_tag_c] = 1'b1;

        // Dcache response wins; a free ack slot lets a local completion bypass the pending register
        if (rsp_hit_c) begin
            ack_d     = 1'b1;
            ack_tid_d = tag_ctid_q[rsp_tag_c];
        end else if (local_pend_q) begin
            ack_d        = 1'b1;
            ack_tid_d    = local_tid_q;
            ack_err_d    = local_err_q;
            local_pend_d = 1'b0;
        end else if (loc_c) begin
            ack_d     = 1'b1;
            ack_tid_d = tag_ctid_q[sent_tag_c];
        end

        if (loc_c && local_pend_q) begin
            local_pend_d = 1'b1;
            local_err_d  = 1'b0;
            local_tid_d  = tag_ctid_q[sent_tag_c];
        end
        if (unsup_c) begin
            local_pend_d = 1'b1;
            local_err_d  = 1'b1;
            local_tid_d  = core_req_tid_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q           <= IDLE;
            tag_valid_q       <= '0;
            local_pend_q      <= 1'b0;
            local_err_q       <= 1'b0;
            local_tid_q       <= '0;
            core_ack_o        <= 1'b0;
            core_ack_tid_o    <= '0;
            core_ack_err_o    <= 1'b0;
            dcache_req_addr_o <= '0;
            dcache_req_cmo_o  <= '0;
            dcache_req_tid_o  <= '0;
            for (int i = 0; i < int'(NTags); i++) tag_ctid_q[i] <= '0;
        end else begin
            state_q           <= state_d;
            tag_valid_q       <= tag_valid_d;
            local_pend_q      <= local_pend_d;
            local_err_q       <= local_err_d;
            local_tid_q       <= local_tid_d;
            core_ack_o        <= ack_d;
            core_ack_tid_o    <= ack_tid_d;
            core_ack_err_o    <= ack_err_d;
            dcache_req_addr_o <= addr_d;
            dcache_req_cmo_o  <= cmo_d;
            dcache_req_tid_o  <= tid_d;
            if (alloc_c) tag_ctid_q[free_tag_c] <= core_req_tid_i;
        end
    end

    // A response addressed to this port must hit an outstanding tag
    rsp_known_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (WaitRsp && dcache_rsp_valid_i && (dcache_rsp_sid_i == sid_i)) |-> rsp_hit_c);

endmodule

// File: tb/tb_hpdcache_cmo_req_tracker.sv
// Directed bench: one tracker waiting for dcache responses, one acking on dcache acceptance.
module tb_hpdcache_cmo_req_tracker;
    logic clk = 1'b0;
    logic rst_n;
    logic [2:0] sid;
    always #5 clk = ~clk;

    // Instance A: WaitRsp=1
    logic        a_valid, a_ready, a_ack, a_ack_err, a_dvalid, a_dready, a_need, a_rvalid;
    logic [3:0]  a_op;
    logic [39:0] a_addr, a_daddr;
    logic [2:0]  a_tid, a_ack_tid, a_dcmo, a_dsid, a_rsid;
    logic [5:0]  a_dtid, a_rtid;

    // Instance B: WaitRsp=0
    logic        b_valid, b_ready, b_ack, b_ack_err, b_dvalid, b_dready, b_need, b_rvalid;
    logic [3:0]  b_op;
    logic [39:0] b_addr, b_daddr;
    logic [2:0]  b_tid, b_ack_tid, b_dcmo, b_dsid, b_rsid;
    logic [5:0]  b_dtid, b_rtid;

    hpdcache_cmo_req_tracker #(.NTags(4), .WaitRsp(1'b1)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .sid_i(sid),
        .core_req_valid_i(a_valid), .core_req_ready_o(a_ready), .core_req_op_i(a_op),
        .core_req_addr_i(a_addr), .core_req_tid_i(a_tid),
        .core_ack_o(a_ack), .core_ack_tid_o(a_ack_tid), .core_ack_err_o(a_ack_err),
        .dcache_req_valid_o(a_dvalid), .dcache_req_ready_i(a_dready),
        .dcache_req_addr_o(a_daddr), .dcache_req_cmo_o(a_dcmo), .dcache_req_sid_o(a_dsid),
        .dcache_req_tid_o(a_dtid), .dcache_req_need_rsp_o(a_need),
        .dcache_rsp_valid_i(a_rvalid), .dcache_rsp_tid_i(a_rtid), .dcache_rsp_sid_i(a_rsid)
    );

    hpdcache_cmo_req_tracker #(.NTags(4), .WaitRsp(1'b0)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .sid_i(sid),
        .core_req_valid_i(b_valid), .core_req_ready_o(b_ready), .core_req_op_i(b_op),
        .core_req_addr_i(b_addr), .core_req_tid_i(b_tid),
        .core_ack_o(b_ack), .core_ack_tid_o(b_ack_tid), .core_ack_err_o(b_ack_err),
        .dcache_req_valid_o(b_dvalid), .dcache_req_ready_i(b_dready),
        .dcache_req_addr_o(b_daddr), .dcache_req_cmo_o(b_dcmo), .dcache_req_sid_o(b_dsid),
        .dcache_req_tid_o(b_dtid), .dcache_req_need_rsp_o(b_need),
        .dcache_rsp_valid_i(b_rvalid), .dcache_rsp_tid_i(b_rtid), .dcache_rsp_sid_i(b_rsid)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int          rsp_order [4] = '{2, 0, 3, 1};
    int          ack_expect[4] = '{3, 1, 4, 2};
    int          n_acks;
    logic        got;
    logic [2:0]  got_tid;
    logic        got_err;

    initial begin
        rst_n = 1'b0; sid = 3'd2;
        a_valid = 0; a_op = 0; a_addr = 0; a_tid = 0; a_dready = 0; a_rvalid = 0; a_rtid = 0; a_rsid = 0;
        b_valid = 0; b_op = 0; b_addr = 0; b_tid = 0; b_dready = 0; b_rvalid = 0; b_rtid = 0; b_rsid = 0;
        repeat (2) tick();
        check("rst_ack", a_ack, 0);
        check("rst_dvalid", a_dvalid, 0);
        check("rst_daddr", a_daddr, 0);
        check("rst_dcmo", a_dcmo, 0);
        check("rst_ready", a_ready, 1);
        check("need_rsp_a", a_need, 1);
        check("need_rsp_b", b_need, 0);
        check("sid_out", a_dsid, 2);
        check("sid_out_b", b_dsid, 2);
        rst_n = 1'b1;
        tick();

        // Fill all four tags with back-to-back INVALs
        a_dready = 1;
        for (int i = 0; i < 4; i++) begin
            a_valid = 1; a_op = 4'd2; a_tid = 3'(i + 1); a_addr = 40'h100 + 40'(i * 64);
            #1 check($sformatf("fill_ready%0d", i), a_ready, 1);
            tick();
            check($sformatf("fill_dvalid%0d", i), a_dvalid, 1);
            check($sformatf("fill_dtid%0d", i), a_dtid, i);
            check($sformatf("fill_cmo%0d", i), a_dcmo, 3);
            check($sformatf("fill_addr%0d", i), a_daddr, 40'h100 + 40'(i * 64));
        end
        a_tid = 3'd6;
        #1 check("full_ready", a_ready, 0);
        tick();
        check("full_dvalid", a_dvalid, 0);
        check("full_ready2", a_ready, 0);
        a_valid = 0;

        // Response for another port is ignored
        a_rvalid = 1; a_rtid = 6'd1; a_rsid = 3'd5;
        tick();
        a_rvalid = 0;
        check("foreign_rsp_ack", a_ack, 0);
        check("foreign_rsp_ready", a_ready, 0);

        for (int k = 0; k < 4; k++) begin
            a_rvalid = 1; a_rtid = 6'(rsp_order[k]); a_rsid = 3'd2;
            tick();
            a_rvalid = 0;
            check($sformatf("rsp_ack%0d", k), a_ack, 1);
            check($sformatf("rsp_tid%0d", k), a_ack_tid, ack_expect[k]);
            check($sformatf("rsp_err%0d", k), a_ack_err, 0);
            if (k == 0) check("ready_after_rsp", a_ready, 1);
        end
        tick();
        check("ack_pulse", a_ack, 0);
        check("empty_ready", a_ready, 1);

        // FLUSH_ALL held while dcache stalls three cycles
        a_dready = 0;
        a_valid = 1; a_op = 4'd7; a_addr = 40'h1000; a_tid = 3'd0;
        tick();
        a_valid = 0;
        for (int j = 0; j < 3; j++) begin
            check($sformatf("stall_valid%0d", j), a_dvalid, 1);
            check($sformatf("stall_addr%0d", j), a_daddr, 40'h1000);
            check($sformatf("stall_cmo%0d", j), a_dcmo, 6);
            tick();
        end
        check("stall_valid3", a_dvalid, 1);
        check("stall_tid", a_dtid, 0);
        a_dready = 1;
        tick();
        check("stall_done", a_dvalid, 0);

        // ZERO acked locally with error, two cycles after accept
        a_valid = 1; a_op = 4'd3; a_tid = 3'd5;
        #1 check("zero_ready", a_ready, 1);
        tick();
        a_valid = 0;
        check("zero_ack_early", a_ack, 0);
        check("zero_no_dreq", a_dvalid, 0);
        check("zero_pend_ready", a_ready, 0);
        tick();
        check("zero_ack", a_ack, 1);
        check("zero_tid", a_ack_tid, 5);
        check("zero_err", a_ack_err, 1);
        tick();
        check("zero_ack_pulse", a_ack, 0);

        // ZERO colliding with a dcache response: dcache ack first
        a_valid = 1; a_op = 4'd3; a_tid = 3'd6;
        tick();
        a_valid = 0;
        a_rvalid = 1; a_rtid = 6'd0; a_rsid = 3'd2;
        tick();
        a_rvalid = 0;
        check("coll_first_ack", a_ack, 1);
        check("coll_first_tid", a_ack_tid, 0);
        check("coll_first_err", a_ack_err, 0);
        tick();
        check("coll_second_ack", a_ack, 1);
        check("coll_second_tid", a_ack_tid, 6);
        check("coll_second_err", a_ack_err, 1);
        tick();

        // Reserved op also errors
        a_valid = 1; a_op = 4'd13; a_tid = 3'd2;
        tick();
        a_valid = 0;
        tick();
        check("resv_err", a_ack_err, 1);
        check("resv_tid", a_ack_tid, 2);

        // Reset with three tags in flight
        for (int i = 0; i < 3; i++) begin
            a_valid = 1; a_op = 4'd2; a_tid = 3'(i + 1);
            tick();
        end
        a_valid = 0;
        tick();
        rst_n = 0;
        tick(); tick();
        check("midrst_ack", a_ack, 0);
        rst_n = 1;
        n_acks = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (a_ack) n_acks++;
        end
        check("midrst_no_acks", n_acks, 0);
        check("midrst_ready", a_ready, 1);
        check("midrst_dvalid", a_dvalid, 0);
        a_valid = 1; a_op = 4'd0; a_tid = 3'd4; a_addr = 40'h3000;
        tick();
        a_valid = 0;
        check("midrst_new_tid", a_dtid, 0);
        check("midrst_new_cmo", a_dcmo, 1);
        check("midrst_new_addr", a_daddr, 40'h3000);

        // Ack-on-acceptance mode
        b_dready = 1;
        b_valid = 1; b_op = 4'd5; b_tid = 3'd7; b_addr = 40'h2000;
        tick();
        b_valid = 0;
        check("b_dvalid", b_dvalid, 1);
        check("b_cmo", b_dcmo, 4);
        check("b_tid", b_dtid, 0);
        check("b_addr", b_daddr, 40'h2000);
        got = 0; got_tid = '0; got_err = 1'b1;
        for (int c = 0; c < 4 && !got; c++) begin
            tick();
            if (b_ack) begin
                got = 1; got_tid = b_ack_tid; got_err = b_ack_err;
            end
        end
        check("b_ack_seen", got, 1);
        check("b_ack_tid", got_tid, 7);
        check("b_ack_err", got_err, 0);
        tick();
        check("b_ack_pulse", b_ack, 0);
        check("b_ready", b_ready, 1);
        b_valid = 1; b_op = 4'd1; b_tid = 3'd3; b_addr = 40'h2040;
        tick();
        b_valid = 0;
        check("b_tag_reuse", b_dtid, 0);
        check("b_flush_cmo", b_dcmo, 2);
        tick();
        check("b_ack2", b_ack, 1);
        check("b_ack2_tid", b_ack_tid, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/hpdcache_cmo_req_tracker.md
Name: hpdcache_cmo_req_tracker

Overview:
Parametrised successor of the single-outstanding CVA6 CMO adapter. It converts core CMO requests into HPDcache CMO requests and tracks up to NTags CMOs in flight, each with its own internal tag. It returns per-request acks carrying the original core transaction ID, and flags unsupported operations with an error. It sits between the CVA6 CMO port and one HPDcache requester port.

Parameters:
NTags, 4, maximum outstanding CMOs (1..16); tag width TW = max(1, $clog2(NTags)).
CoreTidWidth, 3, width of core transaction ID.
AddrWidth, 40, CMO address width.
SidWidth, 3, HPDcache source-ID width.
DTidWidth, 6, HPDcache transaction-ID width; DTidWidth >= TW.
WaitRsp, 1, 1: ack on dcache response; 0: ack on dcache acceptance, need_rsp=0.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset
sid_i  in  SidWidth  source ID for this port (static)
core_req_valid_i  in  1  core CMO request valid
core_req_ready_o  out  1  request accepted when valid&ready
core_req_op_i  in  4  0 CLEAN, 1 FLUSH, 2 INVAL, 3 ZERO, 4 PREF_R, 5 PREF_W, 6 CLEAN_ALL, 7 FLUSH_ALL, 8 INVAL_ALL, 9-15 reserved
core_req_addr_i  in  AddrWidth  CMO address
core_req_tid_i  in  CoreTidWidth  core transaction ID
core_ack_o  out  1  completion pulse (one cycle)
core_ack_tid_o  out  CoreTidWidth  tid of completed CMO
core_ack_err_o  out  1  unsupported op
dcache_req_valid_o  out  1  request valid
dcache_req_ready_i  in  1  dcache ready
dcache_req_addr_o  out  AddrWidth  address
dcache_req_cmo_o  out  3  1 CLEAN_NLINE, 2 FLUSH_NLINE, 3 INVAL_NLINE, 4 PREFETCH, 5 CLEAN_ALL, 6 FLUSH_ALL, 7 INVAL_ALL
dcache_req_sid_o  out  SidWidth  equals sid_i
dcache_req_tid_o  out  DTidWidth  zero-extended internal tag
dcache_req_need_rsp_o  out  1  equals WaitRsp
dcache_rsp_valid_i  in  1  dcache response valid
dcache_rsp_tid_i  in  DTidWidth  response tid
dcache_rsp_sid_i  in  SidWidth  response sid

Behaviour:
- Reset (rst_ni async, active-low; clock clk_i): all tag valid bits 0, output register empty, local-ack pending 0. Outputs core_ack_o=0, dcache_req_valid_o=0, all data outputs 0. core_req_ready_o reflects reset state (1).
- Tag table: NTags entries {valid, core_tid}. The free tag is the lowest-index entry with valid=0. Full = all entries valid.
- Output register, 2-state FSM IDLE/SEND. In SEND, dcache_req_valid_o=1 and address/cmo/tid are held stable until dcache_req_ready_i. On handshake: go to IDLE, or load the next request directly (back-to-back, no bubble).
- core_req_ready_o = !full && (IDLE || dcache_req_ready_i) && !local_pend. Purely combinational from state and dcache_req_ready_i; never from core_req_valid_i.
- Accept of a supported op (0-2, 4-8): allocate the free tag, valid=1, store core_tid, load the output register. Latency from accept to dcache_req_valid_o is 1 cycle.
- Op mapping: CLEAN→1, FLUSH→2, INVAL→3, PREF_R/PREF_W→4, CLEAN_ALL→5, FLUSH_ALL→6, INVAL_ALL→7.
- Accept of an unsupported op (ZERO or 9-15): no tag, nothing sent to dcache. Set local_pend with err=1 and the core tid.
- WaitRsp=1 completion: a dcache response with sid match, tid < NTags and entry valid acks that entry's core_tid (err=0) and clears valid. A response with no matching valid entry is ignored (assertion in simulation).
- WaitRsp=0 completion: on dcache handshake, set local_pend with the entry's core_tid and free the tag in the same cycle.
- Ack register: core_ack_o is registered, 1 cycle after the event. One ack per cycle. Priority: dcache response > local_pend. A losing local_pend holds and retries next cycle.
- Tag freed and allocated in the same cycle: the freed tag becomes available the next cycle (allocation uses registered valid bits).
- No ordering guarantee between acks in WaitRsp=1 mode.
- Reset mid-operation: all in-flight entries are discarded and no acks are produced for them.

Test Plan:
- NTags=4, WaitRsp=1: 4 INVAL tids 1,2,3,4 with ready=1 → dcache tids 0,1,2,3, cmo=3, back-to-back valid. 5th request sees core_req_ready_o=0 until a response arrives.
- Responses in order tid 2,0,3,1 → acks core tids 3,1,4,2, one cycle after each response, err=0. Table empties; ready returns to 1.
- dcache_req_ready_i low 3 cycles with FLUSH_ALL addr 0x1000 → valid held, addr 0x1000 and cmo=6 stable. Handshake occurs on the 4th cycle.
- ZERO op with tid 5 → no dcache request; core_ack_o=1, tid 5, err=1 two cycles after accept. When it collides with a dcache-response ack, the dcache ack comes first and the ZERO ack one cycle later.
- WaitRsp=0, PREF_W tid 7 → dcache need_rsp=0, cmo=4; ack tid 7 one cycle after the dcache handshake.
- Assert reset with 3 tags in flight, then release → no acks, ready=1, a new request gets tag 0.
